// File: rtl/procesamiento_entradas_sync.sv
// Button front end for the ALU: two-flop sync and a per-button debounce channel,
// then a registered level/toggle output stage with a one-cycle change strobe.

module procesamiento_entradas_sync_ch #(
    parameter int DB_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic stable
);
    localparam int               CNT_W    = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The count only survives while sync2 keeps disagreeing with stable, so a
    // short glitch is forgotten instead of being accumulated.
    always_comb begin
        sync1_d  = btn_raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;
endmodule

module procesamiento_entradas_sync #(
    parameter int OP_W      = 3,
    parameter int CANT_W    = 2,
    parameter int DB_CYCLES = 1000,
    parameter int MODE      = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OP_W-1:0]   btn_op,
    input  logic [CANT_W-1:0] btn_cant,
    output logic [OP_W-1:0]   ALUControl,
    output logic [CANT_W-1:0] Cantidad,
    output logic              cambio
);
    localparam int N = OP_W + CANT_W;

    logic [N-1:0] btn_raw;
    logic [N-1:0] stable;
    logic [N-1:0] stable_prev_q, stable_prev_d;
    logic [N-1:0] out_q, out_d;
    logic         cambio_q, cambio_d;

    // Operation buttons occupy the upper bits, amount buttons the lower bits.
    assign btn_raw = {btn_op, btn_cant};

    for (genvar i = 0; i < N; i++) begin : g_ch
        procesamiento_entradas_sync_ch #(
            .DB_CYCLES (DB_CYCLES)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .btn_raw (btn_raw[i]),
            .stable  (stable[i])
        );
    end

    // Toggle mode flips a bit on a debounced press only; releases are ignored.
    always_comb begin
        stable_prev_d = stable;
        if (MODE == 1) begin
            out_d = out_q ^ (stable & ~stable_prev_q);
        end else begin
            out_d = stable;
        end
        cambio_d = (out_d != out_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stable_prev_q <= '0;
            out_q         <= '0;
            cambio_q      <= 1'b0;
        end else begin
            stable_prev_q <= stable_prev_d;
            out_q         <= out_d;
            cambio_q      <= cambio_d;
        end
    end

    assign ALUControl = out_q[N-1:CANT_W];
    assign Cantidad   = out_q[CANT_W-1:0];
    assign cambio     = cambio_q;
endmodule

// File: doc/procesamiento_entradas_sync.md
Name: procesamiento_entradas_sync

Overview:
Parametrised, clocked successor to the combinational button-to-control decoder. It synchronises and debounces the raw board buttons, then drives ALUControl and Cantidad from registers. Two modes are supported: level mode, where outputs follow the held buttons, and toggle mode, where each press flips a bit. A one-cycle change strobe is emitted. The block sits between the board pins and the ALU datapath.

Parameters:
OP_W, 3, number of operation-select buttons and width of ALUControl.
CANT_W, 2, number of amount-select buttons and width of Cantidad.
DB_CYCLES, 1000, consecutive stable clock cycles required to accept a button transition; legal range is 1 or more.
MODE, 0, 0 = level (outputs mirror debounced buttons); 1 = toggle (debounced rising edge flips the matching output bit).

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
btn_op  in  OP_W  raw operation buttons, asynchronous; bit2=btnL, bit1=btnC, bit0=btnR at default width.
btn_cant  in  CANT_W  raw amount buttons, asynchronous; bit1=btnU, bit0=btnD at default width.
ALUControl  out  OP_W  registered operation code.
Cantidad  out  CANT_W  registered amount.
cambio  out  1  one-cycle pulse, high in the cycle where ALUControl or Cantidad differs from its previous value.

Behaviour:
- Reset (rst=1 at an edge) clears everything to 0: both synchroniser flops per button, all debounce counters, all stable states, ALUControl, Cantidad and cambio.
- Reset dominates all other activity. Reset mid-debounce discards the count. After reset the stable state is 0, so a button already held re-qualifies from scratch.
- Synchroniser: two flops per button, no combinational path from raw input to any output.
- Debounce, one independent channel per button (OP_W+CANT_W channels):
  - Counter width is clog2(DB_CYCLES+1).
  - On each edge where sync2 != stable, the counter increments.
  - On the edge where the counter would reach DB_CYCLES, stable takes sync2 and the counter clears.
  - Any edge with sync2 == stable clears the counter, so a glitch shorter than DB_CYCLES is fully rejected and never saturates the counter.
- Output stage:
  - MODE=0: ALUControl <= stable_op; Cantidad <= stable_cant, registered one edge after stable.
  - MODE=1: per bit, the output bit inverts on the edge after stable goes 0->1. Stable 1->0 has no effect.
  - Simultaneous qualifying edges on several buttons are all applied in the same cycle.
- Latency: raw transition first sampled at edge E0 -> output changes at edge E0+DB_CYCLES+2.
- cambio: registered alongside the outputs. It is 1 for exactly one cycle when the new {ALUControl,Cantidad} != old, otherwise 0.
  - Never asserted out of reset.
  - Not asserted in MODE=1 on a release.
- Channels are fully independent: activity on one button never delays or resets another's counter.
- Mapping in MODE=0 is identity, {btnL,btnC,btnR} -> ALUControl and {btnU,btnD} -> Cantidad, with no default/other encodings.

Test Plan:
1. Reset: hold rst 3 cycles with all buttons pressed -> ALUControl=0, Cantidad=0, cambio=0 throughout; outputs rise only DB_CYCLES+2 edges after rst drops.
2. Level press, DB_CYCLES=4, MODE=0: raise btn_op=3'b101 at edge 0 and hold -> ALUControl=3'b101 after edge 6; cambio=1 for exactly that cycle; release -> ALUControl=0 after a further 6 edges, with one cambio pulse.
3. Glitch rejection, DB_CYCLES=4: pulse btn_cant[1] high for 3 cycles -> Cantidad stays 2'b00 and cambio never asserts; 4-cycle pulse -> Cantidad=2'b10.
4. Bounce: toggle btnC 1-0-1-0-1 at 1-cycle spacing then hold 1 -> single clean transition; ALUControl=3'b010 exactly DB_CYCLES+2 edges after the final rising sample.
5. Toggle mode, MODE=1: press/release btnD twice -> Cantidad goes 01 then 00; cambio pulses twice, none on releases; press btnL and btnR in the same cycle -> ALUControl flips 000->101 in one cycle.
6. Reset mid-debounce: assert rst when the btnU counter = DB_CYCLES-1 -> no Cantidad change; after release the full DB_CYCLES+2 latency applies again.
